// File: rtl/max_pool_nch.sv
// 2x2 / stride-2 max pooling over NUM_CH parallel signed channels, raster input,
// valid/ready on both sides. Odd trailing columns/rows are accepted and dropped.
module max_pool_nch #(
    parameter int unsigned NUM_CH  = 6,
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned IMG_W   = 28,
    parameter int unsigned IMG_H   = 28,
    parameter bit          RELU_EN = 1'b0
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_feature_valid,
    input  logic [NUM_CH*DATA_W-1:0] i_features,
    output logic                     o_ready_feature,
    output logic                     o_feature_valid,
    output logic [NUM_CH*DATA_W-1:0] o_features,
    output logic                     o_frame_last,
    input  logic                     i_ready_feature
);

    localparam int unsigned VEC_W  = NUM_CH * DATA_W;
    localparam int unsigned OUT_W  = IMG_W / 2;
    localparam int unsigned OUT_H  = IMG_H / 2;
    localparam int unsigned COL_W  = $clog2(IMG_W);
    localparam int unsigned ROW_W  = $clog2(IMG_H);
    localparam int unsigned BUF_AW = (OUT_W > 1) ? $clog2(OUT_W) : 1;

    logic [COL_W-1:0]  col_q, col_d;
    logic [ROW_W-1:0]  row_q, row_d;
    logic [VEC_W-1:0]  hold_q, hold_d;
    logic              valid_q, valid_d;
    logic [VEC_W-1:0]  data_q, data_d;
    logic              last_q, last_d;
    logic [VEC_W-1:0]  rowbuf_q [OUT_W];

    logic              accept;
    logic              col_odd;
    logic              row_odd;
    logic              buf_we;
    logic [BUF_AW-1:0] buf_idx;
    logic [VEC_W-1:0]  h_vec;
    logic [VEC_W-1:0]  res_vec;

    // A held output only blocks input when downstream is not taking it this cycle.
    assign o_ready_feature = !valid_q || i_ready_feature;
    assign accept          = i_feature_valid && o_ready_feature;
    assign col_odd         = col_q[0];
    assign row_odd         = row_q[0];
    assign buf_idx         = BUF_AW'(col_q >> 1);
    // Writes from a discarded odd trailing row land in the buffer but are always
    // overwritten by row 0 of the next frame before row 1 reads them.
    assign buf_we          = accept && col_odd && !row_odd;

    // Per-channel horizontal max, vertical max against the row buffer, optional ReLU.
    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        logic signed [DATA_W-1:0] smp, hld, rb, h, m;
        assign smp = i_features[k*DATA_W +: DATA_W];
        assign hld = hold_q[k*DATA_W +: DATA_W];
        assign rb  = rowbuf_q[buf_idx][k*DATA_W +: DATA_W];
        assign h   = (smp > hld) ? smp : hld;
        assign m   = (h > rb) ? h : rb;
        assign h_vec[k*DATA_W +: DATA_W]   = h;
        assign res_vec[k*DATA_W +: DATA_W] = (RELU_EN && m[DATA_W-1]) ? '0 : m;
    end

    // Next-state: raster counters, hold register, output register handshake.
    always_comb begin
        col_d   = col_q;
        row_d   = row_q;
        hold_d  = hold_q;
        valid_d = valid_q && !i_ready_feature;
        data_d  = data_q;
        last_d  = last_q;
        if (accept) begin
            if (col_q == COL_W'(IMG_W - 1)) begin
                col_d = '0;
                row_d = (row_q == ROW_W'(IMG_H - 1)) ? '0 : row_q + 1'b1;
            end else begin
                col_d = col_q + 1'b1;
            end
            if (!col_odd) begin
                hold_d = i_features;
            end
            if (col_odd && row_odd) begin
                valid_d = 1'b1;
                data_d  = res_vec;
                last_d  = (row_q == ROW_W'(2 * OUT_H - 1)) && (col_q == COL_W'(2 * OUT_W - 1));
            end
        end
    end

    // State register with synchronous reset.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            col_q   <= '0;
            row_q   <= '0;
            hold_q  <= '0;
            valid_q <= 1'b0;
            data_q  <= '0;
            last_q  <= 1'b0;
        end else begin
            col_q   <= col_d;
            row_q   <= row_d;
            hold_q  <= hold_d;
            valid_q <= valid_d;
            data_q  <= data_d;
            last_q  <= last_d;
        end
    end

    // Row buffer: distributed RAM, no reset needed since row 0 fills it before use.
    always_ff @(posedge i_clk) begin
        if (buf_we) begin
            rowbuf_q[buf_idx] <= h_vec;
        end
    end

    assign o_feature_valid = valid_q;
    assign o_features      = data_q;
    assign o_frame_last    = last_q;

endmodule

// File: tb/tb_max_pool_nch.sv
// Directed bench for max_pool_nch: three instances (4x4, 4x4 ReLU, 5x5), six channels each.
module tb_max_pool_nch;

    localparam int NCH = 6;
    localparam int DW  = 8;
    localparam int VW  = NCH * DW;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [VW-1:0] feat = '0;
    logic          va = 1'b0, vb = 1'b0, vc = 1'b0;
    logic          rdy_set_a = 1'b1;
    logic          rand_mode = 1'b0;
    logic          rnd_bit = 1'b1;
    logic          rdy_a;
    logic          rdy_one = 1'b1;

    logic          ordy_a, ov_a, ol_a;
    logic [VW-1:0] of_a;
    logic          ordy_b, ov_b, ol_b;
    logic [VW-1:0] of_b;
    logic          ordy_c, ov_c, ol_c;
    logic [VW-1:0] of_c;

    int n_asrt = 0;
    int n_fail = 0;
    int cyc = 0;
    int acc_a = 0, acc_c = 0;
    int acc_cyc_a[$];
    logic [VW-1:0] qa_d[$], qb_d[$], qc_d[$];
    logic          qa_l[$], qb_l[$], qc_l[$];
    int            qa_c[$];
    logic [VW-1:0] frm[16];
    logic [VW-1:0] exp_q[$];

    assign rdy_a = rand_mode ? rnd_bit : rdy_set_a;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        rnd_bit <= 1'($urandom_range(0, 1));
    end

    max_pool_nch #(.NUM_CH(NCH), .DATA_W(DW), .IMG_W(4), .IMG_H(4), .RELU_EN(1'b0)) u_a (
        .i_clk(clk), .i_rst(rst), .i_feature_valid(va), .i_features(feat),
        .o_ready_feature(ordy_a), .o_feature_valid(ov_a), .o_features(of_a),
        .o_frame_last(ol_a), .i_ready_feature(rdy_a)
    );

    max_pool_nch #(.NUM_CH(NCH), .DATA_W(DW), .IMG_W(4), .IMG_H(4), .RELU_EN(1'b1)) u_b (
        .i_clk(clk), .i_rst(rst), .i_feature_valid(vb), .i_features(feat),
        .o_ready_feature(ordy_b), .o_feature_valid(ov_b), .o_features(of_b),
        .o_frame_last(ol_b), .i_ready_feature(rdy_one)
    );

    max_pool_nch #(.NUM_CH(NCH), .DATA_W(DW), .IMG_W(5), .IMG_H(5), .RELU_EN(1'b0)) u_c (
        .i_clk(clk), .i_rst(rst), .i_feature_valid(vc), .i_features(feat),
        .o_ready_feature(ordy_c), .o_feature_valid(ov_c), .o_features(of_c),
        .o_frame_last(ol_c), .i_ready_feature(rdy_one)
    );

    // Record accepted input beats and consumed output beats away from the clock edge.
    always @(negedge clk) begin
        if (va && ordy_a) begin
            acc_a++;
            acc_cyc_a.push_back(cyc);
        end
        if (vc && ordy_c) acc_c++;
        if (ov_a && rdy_a) begin
            qa_d.push_back(of_a);
            qa_l.push_back(ol_a);
            qa_c.push_back(cyc);
        end
        if (ov_b && rdy_one) begin
            qb_d.push_back(of_b);
            qb_l.push_back(ol_b);
        end
        if (ov_c && rdy_one) begin
            qc_d.push_back(of_c);
            qc_l.push_back(ol_c);
        end
    end

    function automatic logic [VW-1:0] rep(input logic [DW-1:0] v);
        return {NCH{v}};
    endfunction

    // Reference 2x2 max of window wi over the 4x4 frame in frm.
    function automatic logic [VW-1:0] pool_exp(input int wi);
        logic [VW-1:0] r;
        logic signed [DW-1:0] m, v;
        int base;
        int offs[4];
        offs = '{0, 1, 4, 5};
        base = (wi / 2) * 8 + (wi % 2) * 2;
        r = '0;
        for (int k = 0; k < NCH; k++) begin
            m = frm[base][k*DW +: DW];
            for (int j = 1; j < 4; j++) begin
                v = frm[base + offs[j]][k*DW +: DW];
                if (v > m) m = v;
            end
            r[k*DW +: DW] = m;
        end
        return r;
    endfunction

    function automatic logic [VW-1:0] pix(input int mode, input int i);
        case (mode)
            0:       return rep(DW'(i));
            1:       return rep(DW'(-i - 1));
            default: return frm[i];
        endcase
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_asrt++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Present one beat to the selected instance and hold it until accepted.
    task automatic send(input int which, input logic [VW-1:0] px);
        bit got;
        if (rand_mode) step($urandom_range(0, 2));
        feat = px;
        got = 1'b0;
        case (which)
            0: va = 1'b1;
            1: vb = 1'b1;
            default: vc = 1'b1;
        endcase
        for (int i = 0; i < 500 && !got; i++) begin
            @(negedge clk);
            case (which)
                0: got = ordy_a;
                1: got = ordy_b;
                default: got = ordy_c;
            endcase
            @(posedge clk);
            #1;
        end
        va = 1'b0;
        vb = 1'b0;
        vc = 1'b0;
        if (!got) chk("send_timeout", 64'(got), 64'd1);
    endtask

    task automatic frame(input int which, input int mode, input int lo, input int hi);
        for (int i = lo; i <= hi; i++) send(which, pix(mode, i));
    endtask

    task automatic pop_chk(input int which, input string tag, input logic [VW-1:0] ed,
                           input logic el);
        logic [VW-1:0] d;
        logic l;
        bit have;
        d = '0;
        l = 1'b0;
        case (which)
            0: begin
                have = qa_d.size() > 0;
                if (have) begin d = qa_d.pop_front(); l = qa_l.pop_front(); end
            end
            1: begin
                have = qb_d.size() > 0;
                if (have) begin d = qb_d.pop_front(); l = qb_l.pop_front(); end
            end
            default: begin
                have = qc_d.size() > 0;
                if (have) begin d = qc_d.pop_front(); l = qc_l.pop_front(); end
            end
        endcase
        chk({tag, "_present"}, 64'(have), 64'd1);
        if (have) begin
            chk({tag, "_data"}, 64'(d), 64'(ed));
            chk({tag, "_last"}, 64'(l), 64'(el));
        end
    endtask

    task automatic flush();
        qa_d.delete(); qa_l.delete(); qa_c.delete(); acc_cyc_a.delete();
        qb_d.delete(); qb_l.delete(); qc_d.delete(); qc_l.delete();
        acc_a = 0;
        acc_c = 0;
    endtask

    initial begin
        int lat_beats[4];
        lat_beats = '{5, 7, 13, 15};

        // Reset state
        step(2);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_valid", 64'(ov_a), 64'd0);
        chk("rst_data", 64'(of_a), 64'd0);
        chk("rst_last", 64'(ol_a), 64'd0);
        chk("rst_ready", 64'(ordy_a), 64'd1);
        @(posedge clk);
        #1;

        // Basic 4x4 frame with latency check
        flush();
        frame(0, 0, 0, 15);
        step(3);
        for (int w = 0; w < 4; w++) begin
            if (qa_c.size() > w && acc_cyc_a.size() > lat_beats[w])
                chk("basic_latency", 64'(qa_c[w] - acc_cyc_a[lat_beats[w]]), 64'd1);
            else
                chk("basic_latency_avail", 64'd0, 64'd1);
        end
        pop_chk(0, "basic0", rep(8'd5), 1'b0);
        pop_chk(0, "basic1", rep(8'd7), 1'b0);
        pop_chk(0, "basic2", rep(8'd13), 1'b0);
        pop_chk(0, "basic3", rep(8'd15), 1'b1);

        // Signed compare without and with ReLU
        flush();
        frame(0, 1, 0, 15);
        frame(1, 1, 0, 15);
        step(3);
        pop_chk(0, "neg0", rep(8'hff), 1'b0);
        pop_chk(0, "neg1", rep(8'hfd), 1'b0);
        pop_chk(0, "neg2", rep(8'hf7), 1'b0);
        pop_chk(0, "neg3", rep(8'hf5), 1'b1);
        for (int w = 0; w < 4; w++) pop_chk(1, "relu", '0, 1'(w == 3));

        // Multi-channel, distinct value per channel
        flush();
        for (int i = 0; i < 16; i++)
            for (int k = 0; k < NCH; k++) frm[i][k*DW +: DW] = DW'((i * (k + 1)) % 128);
        frame(0, 2, 0, 15);
        step(3);
        for (int w = 0; w < 4; w++) pop_chk(0, "multich", pool_exp(w), 1'(w == 3));

        // Odd geometry, two back-to-back frames
        flush();
        frame(2, 0, 0, 24);
        frame(2, 0, 0, 24);
        step(3);
        chk("odd_accepts", 64'(acc_c), 64'd50);
        for (int f = 0; f < 2; f++) begin
            pop_chk(2, "odd0", rep(8'd6), 1'b0);
            pop_chk(2, "odd1", rep(8'd8), 1'b0);
            pop_chk(2, "odd2", rep(8'd16), 1'b0);
            pop_chk(2, "odd3", rep(8'd18), 1'b1);
        end

        // Backpressure: stall 10 cycles while the first result is held
        flush();
        frame(0, 0, 0, 5);
        rdy_set_a = 1'b0;
        fork
            frame(0, 0, 6, 15);
            begin
                for (int i = 0; i < 10; i++) begin
                    @(negedge clk);
                    chk("bp_hold_data", 64'(of_a), 64'(rep(8'd5)));
                    chk("bp_hold_valid", 64'(ov_a), 64'd1);
                    chk("bp_ready_low", 64'(ordy_a), 64'd0);
                end
                @(posedge clk);
                #1;
                rdy_set_a = 1'b1;
            end
        join
        step(3);
        chk("bp_accepts", 64'(acc_a), 64'd16);
        pop_chk(0, "bp0", rep(8'd5), 1'b0);
        pop_chk(0, "bp1", rep(8'd7), 1'b0);
        pop_chk(0, "bp2", rep(8'd13), 1'b0);
        pop_chk(0, "bp3", rep(8'd15), 1'b1);

        // Random valid/ready over 3 frames against the reference model
        flush();
        exp_q.delete();
        rand_mode = 1'b1;
        for (int f = 0; f < 3; f++) begin
            for (int i = 0; i < 16; i++) frm[i] = {$urandom(), $urandom()};
            for (int w = 0; w < 4; w++) exp_q.push_back(pool_exp(w));
            frame(0, 3, 0, 15);
        end
        rand_mode = 1'b0;
        step(4);
        chk("rand_count", 64'(qa_d.size()), 64'd12);
        for (int j = 0; j < 12; j++) pop_chk(0, "rand", exp_q[j], 1'((j % 4) == 3));

        // Reset mid-frame with an output pending
        flush();
        rdy_set_a = 1'b0;
        frame(0, 0, 0, 5);
        rst = 1'b1;
        va = 1'b1;
        feat = rep(8'd99);
        step(1);
        rst = 1'b0;
        va = 1'b0;
        @(negedge clk);
        chk("mid_rst_valid", 64'(ov_a), 64'd0);
        chk("mid_rst_data", 64'(of_a), 64'd0);
        chk("mid_rst_ready", 64'(ordy_a), 64'd1);
        @(posedge clk);
        #1;
        rdy_set_a = 1'b1;
        flush();
        frame(0, 0, 0, 15);
        step(3);
        pop_chk(0, "post_rst0", rep(8'd5), 1'b0);
        pop_chk(0, "post_rst1", rep(8'd7), 1'b0);
        pop_chk(0, "post_rst2", rep(8'd13), 1'b0);
        pop_chk(0, "post_rst3", rep(8'd15), 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
        $finish;
    end

endmodule
